// File: rtl/tile_collide_pkg.sv
// Shared types for the sequential tile collision sweeper.
// Direction bit positions, corner/state enums and the bounce rule.
package tile_collide_pkg;

    localparam int DIR_U = 3;
    localparam int DIR_D = 2;
    localparam int DIR_L = 1;
    localparam int DIR_R = 0;

    typedef enum logic [1:0] {TL, TR, BL, BR} corner_t;

    typedef enum logic [2:0] {
        IDLE, ISSUE, WAIT, EVAL, PUBLISH
    } state_t;

    function automatic logic [3:0] bounce_rule(
        input corner_t   c,
        input logic [3:0] m
    );
        logic [3:0] r;
        r = '0;
        unique case (c)
            TL: if (m[DIR_L]) r[DIR_R] = 1'b1;
                else if (m[DIR_U]) r[DIR_D] = 1'b1;
            TR: if (m[DIR_R]) r[DIR_L] = 1'b1;
                else if (m[DIR_U]) r[DIR_D] = 1'b1;
            BL: if (m[DIR_L]) r[DIR_R] = 1'b1;
                else if (m[DIR_D]) r[DIR_U] = 1'b1;
            BR: if (m[DIR_R]) r[DIR_L] = 1'b1;
                else if (m[DIR_D]) r[DIR_U] = 1'b1;
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tile_collide_seq_addr.sv
// Corner-to-tile address: widened sums, tile coords,
// out-of-bounds flag and linear map index.
module tile_corner_addr
    import tile_collide_pkg::*;
#(
    parameter int MAP_W      = 20,
    parameter int MAP_H      = 15,
    parameter int TILE_SHIFT = 5,
    parameter int POS_W      = 10,
    parameter int DIM_W      = 10,
    parameter int ADDR_W     = $clog2(MAP_W*MAP_H)
) (
    input  logic [POS_W-1:0]  x_i,
    input  logic [POS_W-1:0]  y_i,
    input  logic [DIM_W-1:0]  w_i,
    input  logic [DIM_W-1:0]  h_i,
    input  corner_t           corner_i,
    output logic              oob_o,
    output logic [ADDR_W-1:0] addr_o
);

    localparam int SW = ((POS_W > DIM_W) ? POS_W : DIM_W) + 1;

    logic [SW-1:0] xs, ys, tx, ty;
    logic          right, bottom;

    always_comb begin
        right  = (corner_i == TR) || (corner_i == BR);
        bottom = (corner_i == BL) || (corner_i == BR);
        xs     = SW'(x_i) + (right  ? SW'(w_i) : '0);
        ys     = SW'(y_i) + (bottom ? SW'(h_i) : '0);
        tx     = xs >> TILE_SHIFT;
        ty     = ys >> TILE_SHIFT;
        oob_o  = (tx >= SW'(MAP_W)) || (ty >= SW'(MAP_H));
        addr_o = oob_o ? '0 : ADDR_W'(ty * MAP_W + tx);
    end

endmodule

// File: rtl/tile_collide_seq.sv
// Per-frame sweep of every sprite's four corners through a
// 1-cycle map read port; bounce results published atomically.
module tile_collide_seq
    import tile_collide_pkg::*;
#(
    parameter int N_SPR      = 4,
    parameter int MAP_W      = 20,
    parameter int MAP_H      = 15,
    parameter int TILE_SHIFT = 5,
    parameter int POS_W      = 10,
    parameter int DIM_W      = 10,
    parameter int ADDR_W     = $clog2(MAP_W*MAP_H)
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   frame_start,
    input  logic [N_SPR*POS_W-1:0] spr_x,
    input  logic [N_SPR*POS_W-1:0] spr_y,
    input  logic [N_SPR*DIM_W-1:0] spr_w,
    input  logic [N_SPR*DIM_W-1:0] spr_h,
    input  logic [N_SPR*4-1:0]     dir,
    input  logic [N_SPR*4-1:0]     bcing,
    output logic                   map_rd,
    output logic [ADDR_W-1:0]      map_addr,
    input  logic                   map_wall,
    output logic [N_SPR*4-1:0]     bnce,
    output logic [N_SPR-1:0]       coll,
    output logic                   busy,
    output logic                   done,
    output logic                   overrun
);

    localparam int IW = (N_SPR > 1) ? $clog2(N_SPR) : 1;

    state_t                 state_q, state_d;
    corner_t                corner_q, corner_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [N_SPR*POS_W-1:0] x_q, x_d, y_q, y_d;
    logic [N_SPR*DIM_W-1:0] w_q, w_d, h_q, h_d;
    logic [N_SPR*4-1:0]     dir_q, dir_d, bc_q, bc_d;
    logic [3:0]             hit_q, hit_d;
    logic [N_SPR*4-1:0]     shadow_q, shadow_d;
    logic [N_SPR*4-1:0]     bnce_q, bnce_d;
    logic [N_SPR-1:0]       coll_q, coll_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   ovr_q, ovr_d;

    logic [POS_W-1:0]  cur_x, cur_y;
    logic [DIM_W-1:0]  cur_w, cur_h;
    logic [3:0]        cur_dir, cur_bc, result;
    logic              oob;
    logic [ADDR_W-1:0] addr;
    corner_t           sel;

    assign cur_x   = x_q[int'(idx_q)*POS_W +: POS_W];
    assign cur_y   = y_q[int'(idx_q)*POS_W +: POS_W];
    assign cur_w   = w_q[int'(idx_q)*DIM_W +: DIM_W];
    assign cur_h   = h_q[int'(idx_q)*DIM_W +: DIM_W];
    assign cur_dir = dir_q[int'(idx_q)*4 +: 4];
    assign cur_bc  = bc_q[int'(idx_q)*4 +: 4];

    tile_corner_addr #(
        .MAP_W     (MAP_W),
        .MAP_H     (MAP_H),
        .TILE_SHIFT(TILE_SHIFT),
        .POS_W     (POS_W),
        .DIM_W     (DIM_W),
        .ADDR_W    (ADDR_W)
    ) u_addr (
        .x_i     (cur_x),
        .y_i     (cur_y),
        .w_i     (cur_w),
        .h_i     (cur_h),
        .corner_i(corner_q),
        .oob_o   (oob),
        .addr_o  (addr)
    );

    // First hit corner wins; the same corner drives both rule terms.
    always_comb begin
        sel = BR;
        if (hit_q[TL])      sel = TL;
        else if (hit_q[TR]) sel = TR;
        else if (hit_q[BL]) sel = BL;
        result = '0;
        if (|hit_q)
            result = bounce_rule(sel, cur_dir) | bounce_rule(sel, cur_bc);
    end

    always_comb begin
        state_d  = state_q;
        corner_d = corner_q;
        idx_d    = idx_q;
        x_d      = x_q;
        y_d      = y_q;
        w_d      = w_q;
        h_d      = h_q;
        dir_d    = dir_q;
        bc_d     = bc_q;
        hit_d    = hit_q;
        shadow_d = shadow_q;
        bnce_d   = bnce_q;
        coll_d   = coll_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        ovr_d    = ovr_q;
        map_rd   = 1'b0;
        map_addr = '0;
        if (frame_start && state_q != IDLE) ovr_d = 1'b1;
        unique case (state_q)
            IDLE: begin
                if (frame_start) begin
                    x_d      = spr_x;
                    y_d      = spr_y;
                    w_d      = spr_w;
                    h_d      = spr_h;
                    dir_d    = dir;
                    bc_d     = bcing;
                    ovr_d    = 1'b0;
                    busy_d   = 1'b1;
                    idx_d    = '0;
                    corner_d = TL;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                map_rd   = ~oob;
                map_addr = addr;
                state_d  = WAIT;
            end
            WAIT: begin
                hit_d[corner_q] = oob | map_wall;
                if (corner_q != BR) begin
                    corner_d = corner_t'(corner_q + 2'd1);
                    state_d  = ISSUE;
                end else begin
                    state_d = EVAL;
                end
            end
            EVAL: begin
                shadow_d[int'(idx_q)*4 +: 4] = result;
                if (idx_q != IW'(N_SPR-1)) begin
                    idx_d    = idx_q + IW'(1);
                    corner_d = TL;
                    state_d  = ISSUE;
                end else begin
                    state_d = PUBLISH;
                end
            end
            PUBLISH: begin
                bnce_d = shadow_q;
                for (int i = 0; i < N_SPR; i++)
                    coll_d[i] = |shadow_q[i*4 +: 4];
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= IDLE;
            corner_q <= TL;
            idx_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            w_q      <= '0;
            h_q      <= '0;
            dir_q    <= '0;
            bc_q     <= '0;
            hit_q    <= '0;
            shadow_q <= '0;
            bnce_q   <= '0;
            coll_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            corner_q <= corner_d;
            idx_q    <= idx_d;
            x_q      <= x_d;
            y_q      <= y_d;
            w_q      <= w_d;
            h_q      <= h_d;
            dir_q    <= dir_d;
            bc_q     <= bc_d;
            hit_q    <= hit_d;
            shadow_q <= shadow_d;
            bnce_q   <= bnce_d;
            coll_q   <= coll_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ovr_q    <= ovr_d;
        end
    end

    assign bnce    = bnce_q;
    assign coll    = coll_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign overrun = ovr_q;

endmodule

// File: tb/tb_tile_collide_seq.sv
// Directed bench for tile_collide_seq: map ROM model, address
// and result scoreboards, overrun and mid-sweep reset steps.
module tb_tile_collide_seq;

    logic        clk = 1'b0;
    logic        rst, fs;
    logic [39:0] sx, sy, sw, sh;
    logic [15:0] sd, sb;
    logic        map_rd, map_wall;
    logic [8:0]  map_addr;
    logic [15:0] bnce;
    logic [3:0]  coll;
    logic        busy, done, overrun;

    bit          wall [512];
    logic [8:0]  addr_q [$];
    logic [15:0] exp_q [$];
    int          n_cmp = 0;
    int          n_err = 0;

    tile_collide_seq dut (
        .Clk        (clk),
        .Reset      (rst),
        .frame_start(fs),
        .spr_x      (sx),
        .spr_y      (sy),
        .spr_w      (sw),
        .spr_h      (sh),
        .dir        (sd),
        .bcing      (sb),
        .map_rd     (map_rd),
        .map_addr   (map_addr),
        .map_wall   (map_wall),
        .bnce       (bnce),
        .coll       (coll),
        .busy       (busy),
        .done       (done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // Synchronous map ROM; garbage on cycles with no read.
    always @(posedge clk)
        map_wall <= map_rd ? wall[map_addr] : 1'($urandom());

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (map_rd === 1'b1) begin
            if (addr_q.size() == 0) chk("addr_extra", 32'(map_addr), 32'h3ff);
            else chk("map_addr", 32'(map_addr), 32'(addr_q.pop_front()));
        end
    end

    function automatic logic [3:0] rule_m(input int c, input logic [3:0] m);
        case (c)
            0: return m[1] ? 4'b0001 : (m[3] ? 4'b0100 : 4'b0000);
            1: return m[0] ? 4'b0010 : (m[3] ? 4'b0100 : 4'b0000);
            2: return m[1] ? 4'b0001 : (m[2] ? 4'b1000 : 4'b0000);
            default: return m[0] ? 4'b0010 : (m[2] ? 4'b1000 : 4'b0000);
        endcase
    endfunction

    function automatic logic [3:0] coll_of(input logic [15:0] eb);
        logic [3:0] c;
        for (int i = 0; i < 4; i++) c[i] = |eb[i*4 +: 4];
        return c;
    endfunction

    task automatic predict();
        logic [15:0] eb;
        eb = '0;
        for (int i = 0; i < 4; i++) begin
            int x, y, w, h, sel;
            x = int'(sx[i*10 +: 10]);
            y = int'(sy[i*10 +: 10]);
            w = int'(sw[i*10 +: 10]);
            h = int'(sh[i*10 +: 10]);
            sel = -1;
            for (int c = 0; c < 4; c++) begin
                int xs, ys, tx, ty;
                bit hit;
                xs = x + (((c == 1) || (c == 3)) ? w : 0);
                ys = y + ((c >= 2) ? h : 0);
                tx = xs / 32;
                ty = ys / 32;
                if (tx < 20 && ty < 15) begin
                    addr_q.push_back(9'(ty * 20 + tx));
                    hit = wall[ty * 20 + tx];
                end else begin
                    hit = 1'b1;
                end
                if (hit && sel < 0) sel = c;
            end
            if (sel >= 0)
                eb[i*4 +: 4] = rule_m(sel, sd[i*4 +: 4]) | rule_m(sel, sb[i*4 +: 4]);
        end
        exp_q.push_back(eb);
    endtask

    task automatic set_spr(input int i, input int x, input int y,
                           input int w, input int h,
                           input logic [3:0] d, input logic [3:0] b);
        sx[i*10 +: 10] = 10'(x);
        sy[i*10 +: 10] = 10'(y);
        sw[i*10 +: 10] = 10'(w);
        sh[i*10 +: 10] = 10'(h);
        sd[i*4 +: 4]   = d;
        sb[i*4 +: 4]   = b;
    endtask

    // ovr_cyc / rst_cyc: sweep cycle at which to pulse frame_start / Reset (0 = none).
    task automatic run_sweep(input int ovr_cyc, input int rst_cyc);
        int          cyc;
        bit          seen;
        logic [39:0] keep_x;
        logic [15:0] keep_d, eb;
        @(posedge clk); #1;
        fs = 1'b1;
        predict();
        @(posedge clk); #1;
        fs     = 1'b0;
        cyc    = 1;
        seen   = 1'b0;
        chk("busy_start", 32'(busy), 1);
        chk("ovr_clear", 32'(overrun), 0);
        keep_x = sx;
        keep_d = sd;
        sx     = sx ^ 40'({$urandom(), $urandom()});
        sd     = ~sd;
        while (cyc < 60 && !seen) begin
            if (cyc == ovr_cyc) fs = 1'b1;
            if (cyc == rst_cyc) rst = 1'b1;
            @(posedge clk); #1;
            cyc++;
            fs = 1'b0;
            if (rst) begin
                rst = 1'b0;
                chk("rst_bnce", 32'(bnce), 0);
                chk("rst_coll", 32'(coll), 0);
                chk("rst_busy", 32'(busy), 0);
                chk("rst_maprd", 32'(map_rd), 0);
                chk("rst_ovr", 32'(overrun), 0);
                addr_q.delete();
                void'(exp_q.pop_back());
                sx = keep_x;
                sd = keep_d;
                return;
            end
            if (done) seen = 1'b1;
        end
        chk("done_cycle", 32'(cyc), 38);
        eb = exp_q.pop_front();
        chk("bnce", 32'(bnce), 32'(eb));
        chk("coll", 32'(coll), 32'(coll_of(eb)));
        chk("busy_at_done", 32'(busy), 0);
        chk("overrun", 32'(overrun), (ovr_cyc > 0) ? 1 : 0);
        chk("addr_left", 32'(addr_q.size()), 0);
        @(posedge clk); #1;
        chk("done_pulse", 32'(done), 0);
        chk("idle_after", 32'(busy), 0);
        sx = keep_x;
        sd = keep_d;
    endtask

    initial begin
        rst = 1'b1;
        fs  = 1'b0;
        sx = '0; sy = '0; sw = '0; sh = '0; sd = '0; sb = '0;
        map_wall = 1'b0;
        for (int i = 0; i < 512; i++) wall[i] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bnce0", 32'(bnce), 0);
        chk("rst_coll0", 32'(coll), 0);
        chk("rst_busy0", 32'(busy), 0);
        chk("rst_done0", 32'(done), 0);
        chk("rst_ovr0", 32'(overrun), 0);
        chk("rst_maprd0", 32'(map_rd), 0);
        chk("rst_addr0", 32'(map_addr), 0);
        rst = 1'b0;
        for (int i = 1; i < 4; i++) set_spr(i, 100 * i + 100, 200, 8, 8, 4'b0, 4'b0);

        set_spr(0, 40, 40, 16, 16, 4'b0010, 4'b0000);
        run_sweep(0, 0);
        chk("t1_bnce0", 32'(bnce[3:0]), 32'h0);

        wall[21] = 1'b1;
        run_sweep(0, 0);
        chk("t2_bnce0_L", 32'(bnce[3:0]), 32'b0001);
        chk("t2_coll0", 32'(coll[0]), 1);
        set_spr(0, 40, 40, 16, 16, 4'b1000, 4'b0000);
        run_sweep(0, 0);
        chk("t2_bnce0_U", 32'(bnce[3:0]), 32'b0100);

        wall[21] = 1'b0;
        wall[22] = 1'b1;
        set_spr(0, 50, 40, 16, 16, 4'b0001, 4'b1000);
        run_sweep(0, 0);
        chk("t3_bnce0", 32'(bnce[3:0]), 32'b0110);

        set_spr(1, 630, 470, 16, 16, 4'b0100, 4'b0000);
        set_spr(2, 600, 470, 16, 16, 4'b0100, 4'b0000);
        run_sweep(0, 0);
        chk("t4_bnce1", 32'(bnce[7:4]), 32'b0000);
        chk("t4_bnce2", 32'(bnce[11:8]), 32'b1000);
        chk("t4_coll", 32'(coll), 32'b0101);

        run_sweep(10, 0);
        run_sweep(0, 0);
        run_sweep(37, 0);

        run_sweep(0, 20);
        run_sweep(0, 0);

        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 300; i++) wall[i] = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < 4; i++)
                set_spr(i, int'($urandom_range(0, 700)), int'($urandom_range(0, 520)),
                        int'($urandom_range(0, 80)), int'($urandom_range(0, 80)),
                        4'($urandom()), 4'($urandom()));
            run_sweep(0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
